dtc_tree_walker: RTL



---
 rtl/dtc_pkg.sv | 30 +++
 rtl/dtc_tree_walker_if.sv | 27 ++
 rtl/dtc_node_table.sv | 28 ++
 rtl/dtc_tree_walker.sv | 100 ++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared types and sizing for the programmable decision-tree walker.
package dtc_pkg;

    localparam int N_FEAT    = 11;
    localparam int OUT_W     = 3;
    localparam int MAX_NODES = 32;
    localparam int MAX_DEPTH = 8;
    localparam int AW        = $clog2(MAX_NODES);
    localparam int FW        = $clog2(N_FEAT);
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    typedef struct packed {
        logic             leaf;
        logic [FW-1:0]    feat;
        logic [AW-1:0]    lo_child;
        logic [AW-1:0]    hi_child;
        logic [OUT_W-1:0] cls;
    } node_t;

    localparam int NODE_W = $bits(node_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam node_t LEAF_RESET = '{leaf: 1'b1, default: '0};

endpackage

// File: rtl/dtc_tree_walker_if.sv
// Feature-in, class-out and node-table config handshakes.
interface dtc_tree_walker_if;
    import dtc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N_FEAT-1:0] inp;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  outp;
    logic              out_err;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NODE_W-1:0] cfg_data;
    logic              cfg_ready;

    modport slave (
        input  in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, outp, out_err, cfg_ready
    );

    modport master (
        output in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, outp, out_err, cfg_ready
    );

endinterface

// File: rtl/dtc_node_table.sv
// Node table: register array, one write port, one async read port.
module dtc_node_table
    import dtc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  node_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output node_t         rdata_o
);

    node_t mem_q [MAX_NODES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                mem_q[i] <= LEAF_RESET;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dtc_tree_walker.sv
// Walks one feature vector through the node table, one node per clock.
module dtc_tree_walker
    import dtc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    dtc_tree_walker_if.slave   bus
);

    localparam int FEAT_SPAN = 1 << FW;

    state_t            state_q;
    logic [AW-1:0]     ptr_q;
    logic [DW-1:0]     depth_q;
    logic [N_FEAT-1:0] inp_q;
    logic [OUT_W-1:0]  outp_q;
    logic              err_q;

    node_t             node;
    logic [FEAT_SPAN-1:0] inp_pad;
    logic [AW-1:0]     child_d;
    logic              feat_bad;
    logic              depth_max;
    logic              child_bad;
    logic              tbl_we;
    logic              accept;

    dtc_node_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (tbl_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (node_t'(bus.cfg_data)),
        .raddr_i (ptr_q),
        .rdata_o (node)
    );

    // Pad so out-of-range feature indices read a defined 0.
    always_comb begin
        inp_pad = '0;
        inp_pad[N_FEAT-1:0] = inp_q;
    end

    assign child_d   = inp_pad[node.feat] ? node.hi_child : node.lo_child;
    assign feat_bad  = {1'b0, node.feat} >= (FW+1)'(N_FEAT);
    assign depth_max = depth_q == DW'(MAX_DEPTH);
    assign child_bad = {1'b0, child_d} >= (AW+1)'(MAX_NODES);

    assign tbl_we = bus.cfg_we && (state_q == IDLE);
    assign accept = bus.in_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            depth_q <= '0;
            inp_q   <= '0;
            outp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        inp_q   <= bus.inp;
                        ptr_q   <= '0;
                        depth_q <= '0;
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    if (node.leaf) begin
                        outp_q  <= node.cls;
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (feat_bad || depth_max || child_bad) begin
                        outp_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ptr_q   <= child_d;
                        depth_q <= depth_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.cfg_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.outp      = outp_q;
    assign bus.out_err   = err_q;

endmodule
